// File: rtl/datapath_pipe_if.sv
// Bundle between the instruction decoder (master) and the pipelined datapath (slave):
// op issue, external register loads, architectural reads, result and flags.
interface datapath_pipe_if #(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 16
);
    localparam int ADDR_W = $clog2(REG_COUNT);

    logic              op_valid;
    logic [2:0]        alu_opcode;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              alu_carry;
    logic              alu_zero;
    logic              ld_collision;

    modport master (
        output op_valid, alu_opcode, ra_addr, rb_addr, rd_addr,
        output ld_en, ld_addr, ld_data,
        input  read_a, read_b, result, result_valid, alu_carry, alu_zero, ld_collision
    );

    modport slave (
        input  op_valid, alu_opcode, ra_addr, rb_addr, rd_addr,
        input  ld_en, ld_addr, ld_data,
        output read_a, read_b, result, result_valid, alu_carry, alu_zero, ld_collision
    );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath: issue (operand capture with forwarding),
// then execute/writeback with registered result and carry/zero flags.
module datapath_pipe #(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 16
) (
    input  logic            clk,
    input  logic            rst,
    datapath_pipe_if.slave  bus
);
    localparam int ADDR_W = $clog2(REG_COUNT);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    logic [DATA_W-1:0] regs [REG_COUNT];

    logic              s1_valid;
    alu_op_e           s1_op;
    logic [ADDR_W-1:0] s1_rd;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   wide;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              collision;

    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic              carry_q;
    logic              zero_q;
    logic              collision_q;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (s1_op)
            OP_ADD: begin
                wide    = {1'b0, s1_a} + {1'b0, s1_b};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow (A < B).
                wide    = {1'b0, s1_a} - {1'b0, s1_b};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_SHL: begin
                alu_res = {s1_a[DATA_W-2:0], 1'b0};
                alu_c   = s1_a[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, s1_a[DATA_W-1:1]};
                alu_c   = s1_a[0];
            end
            OP_PASS: alu_res = s1_a;
            default: alu_res = '0;
        endcase
    end

    // Operand forwarding follows write priority: in-flight result, then same-cycle load.
    always_comb begin
        op_a = regs[bus.ra_addr];
        op_b = regs[bus.rb_addr];
        if (s1_valid && s1_rd == bus.ra_addr)
            op_a = alu_res;
        else if (bus.ld_en && bus.ld_addr == bus.ra_addr)
            op_a = bus.ld_data;
        if (s1_valid && s1_rd == bus.rb_addr)
            op_b = alu_res;
        else if (bus.ld_en && bus.ld_addr == bus.rb_addr)
            op_b = bus.ld_data;
    end

    assign collision = s1_valid && bus.ld_en && (bus.ld_addr == s1_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else begin
            if (bus.ld_en && !collision)
                regs[bus.ld_addr] <= bus.ld_data;
            if (s1_valid)
                regs[s1_rd] <= alu_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_rd    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= bus.op_valid;
            if (bus.op_valid) begin
                s1_op <= alu_op_e'(bus.alu_opcode);
                s1_rd <= bus.rd_addr;
                s1_a  <= op_a;
                s1_b  <= op_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
            collision_q    <= 1'b0;
        end else begin
            result_valid_q <= s1_valid;
            collision_q    <= collision;
            if (s1_valid) begin
                result_q <= alu_res;
                carry_q  <= alu_c;
                zero_q   <= (alu_res == '0);
            end
        end
    end

    assign bus.read_a       = regs[bus.ra_addr];
    assign bus.read_b       = regs[bus.rb_addr];
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.alu_carry    = carry_q;
    assign bus.alu_zero     = zero_q;
    assign bus.ld_collision = collision_q;
endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised, two-stage pipelined successor to the single-cycle register-file/ALU datapath. It holds a REG_COUNT × DATA_W register file, issues one ALU operation per clock, and writes the result back to a destination register one cycle later. It also maintains registered carry/zero flags and forwards in-flight results so back-to-back dependent operations are correct. It sits between the future instruction decoder (op issue and external loads) and the status/branch logic (flags).

## Interface
- DATA_W, 8, datapath and register width (≥2)
- REG_COUNT, 16, number of registers (power of two, ≥2); ADDR_W = $clog2(REG_COUNT) is derived, not a parameter
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- op_valid  input  1  issue an ALU op this cycle
- alu_opcode  input  3  operation (see Operation)
- ra_addr, rb_addr  input  ADDR_W  source operand registers
- rd_addr  input  ADDR_W  destination register for the op
- ld_en  input  1  external register load this cycle
- ld_addr  input  ADDR_W  load target
- ld_data  input  DATA_W  load value
- read_a, read_b  output  DATA_W  combinational architectural read of ra_addr/rb_addr (no forwarding)
- result  output  DATA_W  registered result of the last completed op
- result_valid  output  1  one-cycle pulse, result written this edge
- alu_carry, alu_zero  output  1  registered flags of last completed op
- ld_collision  output  1  one-cycle pulse: a load was dropped because writeback hit the same register

## Operation
- Stage 1 (issue): on an edge with op_valid=1, capture opcode, rd_addr and operands A=reg[ra_addr], B=reg[rb_addr] (forwarded, below) into stage registers; s1_valid ← op_valid.
- Stage 2 (execute/writeback): combinational ALU on stage registers; on the next edge with s1_valid=1: reg[rd] ← res, result ← res, flags update, result_valid ← 1.
- Opcodes (unsigned, DATA_W bits): 000 ADD (carry = carry-out); 001 SUB A−B (carry = borrow, 1 iff A<B); 010 AND; 011 OR; 100 XOR; 101 SHL by 1 (carry = A[MSB]); 110 SHR logical by 1 (carry = A[0]); 111 PASS A. AND/OR/XOR/PASS: carry = 0. zero = (res == 0). Results truncated to DATA_W.
- Flags and result hold their value on edges with s1_valid=0.
- Write priority for the same edge: stage-2 writeback beats ld_en when addresses match; load dropped, ld_collision pulses. Different addresses: both written.
- Operand forwarding at issue: if s1_valid and s1_rd == ra_addr (rb_addr), operand takes the stage-2 ALU result; else if ld_en and ld_addr matches, operand takes ld_data; else register file value. Forwarding priority mirrors write priority.
- read_a/read_b never forward; they show committed register contents.

## Timing
- Reset (async assert, sync release): all registers 0, s1_valid 0, result 0, result_valid 0, alu_carry 0, alu_zero 0, ld_collision 0. In-flight op is discarded (no writeback).
- Latency: op issued at edge k → reg[rd], result, flags, result_valid visible after edge k+1.
- Throughput: one op per cycle, no stalls; dependent back-to-back ops need no bubbles.
- Load latency: ld_en at edge k → visible on read_a/read_b after edge k.
- result_valid and ld_collision are single-cycle pulses; continuous issue holds result_valid high.
- rd == ra/rb (e.g. r1 ← r1+r1) is legal; operands sampled before writeback.

## Test plan
- Reset: preload regs, assert rst mid-op → all outputs 0, all regs 0, no writeback after release.
- Basic ALU: load r1=0x7F, r2=0x81; ADD r3←r1+r2 → result 0x00, carry 1, zero 1 one cycle after issue; SUB r4←r1−r2 → 0xFE, carry 1; SHL r5←r2 → 0x02, carry 1; SHR of r1 → 0x3F, carry 1.
- Forwarding chain: r1=0x01; issue ADD r1←r1+r1 on four consecutive cycles → results 0x02, 0x04, 0x08, 0x10, result_valid high four cycles, read_a(r1)=0x10 at end.
- Load forwarding: ld r6=0x55 and, same cycle, op XOR r7←r6^r6 → r7=0x00, zero 1; PASS r8←r6 issued same cycle as ld r6=0xAA → 0xAA.
- Collision: op writing r2 completes same edge as ld r2=0x33 → r2 holds ALU value, ld_collision 1 for one cycle; ld r9 on same edge succeeds.
- Parameter sweep: DATA_W=16, REG_COUNT=32: ADD 0xFFFF+0x0001 to r31 → 0x0000, carry 1, zero 1; flags hold across idle cycles.
